// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } pipe_ctrl_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: a load in EX whose destination is read by the ID
// instruction. Writes to x0 never create a dependency.
module load_use_detect (
  input  logic       memread_ex,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       uses_rs1_id,
  input  logic       uses_rs2_id,
  output logic       load_use
);
  import pipe_ctrl_pkg::*;

  assign load_use = memread_ex && (rd_ex != REG_X0) &&
                    ((uses_rs1_id && (rs1_id == rd_ex)) ||
                     (uses_rs2_id && (rs2_id == rd_ex)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage core.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal flow; branch / load-use handling, new mem requests
//   MEM_WAIT | data memory has not answered; whole pipe held
//   FAULT    | memory never answered within the timeout; held until reset
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEMREAD_EX,
  input  logic [4:0]       RD_EX,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             USES_RS1_ID,
  input  logic             USES_RS2_ID,
  input  logic             BRANCH_TAKEN_EX,
  input  logic             MEMREAD_MEM,
  input  logic             MEMWRITE_MEM,
  input  logic             DMEM_READY,
  output logic             DMEM_REQ,
  output logic             STALL_IF,
  output logic             STALL_ID,
  output logic             STALL_EX,
  output logic             STALL_MEM,
  output logic             FLUSH_ID,
  output logic             FLUSH_EX,
  output logic             FLUSH_WB,
  output logic             MEM_FAULT,
  output logic [CNT_W-1:0] STALL_COUNT,
  output logic [CNT_W-1:0] FLUSH_COUNT
);
  import pipe_ctrl_pkg::*;

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  pipe_ctrl_state_t  state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_fault;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              access, load_use, mem_busy;

  load_use_detect u_load_use (
    .memread_ex  (MEMREAD_EX),
    .rd_ex       (RD_EX),
    .rs1_id      (RS1_ID),
    .rs2_id      (RS2_ID),
    .uses_rs1_id (USES_RS1_ID),
    .uses_rs2_id (USES_RS2_ID),
    .load_use    (load_use)
  );

  assign access = MEMREAD_MEM | MEMWRITE_MEM;

  // A miss either starts in RUN or continues in MEM_WAIT; the READY cycle itself is not a stall.
  assign mem_busy = !DMEM_READY &&
                    (((state == RUN) && access) || (state == MEM_WAIT));

  // State register, wait counter, sticky fault flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state != MEM_WAIT) && (state_nxt == MEM_WAIT))
        wait_cnt <= '0;
      else if ((state == MEM_WAIT) && !DMEM_READY)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (state_nxt == FAULT)
        mem_fault <= 1'b1;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (access && !DMEM_READY) state_nxt = MEM_WAIT;
      MEM_WAIT: begin
        if (DMEM_READY)                state_nxt = RUN;
        else if (wait_cnt == WAIT_LAST) state_nxt = FAULT;
      end
      FAULT:    state_nxt = FAULT;
      default:  state_nxt = RUN;
    endcase
  end

  // Mealy hazard outputs; priority memory wait > taken branch > load-use, all forced low in reset.
  always_comb begin
    DMEM_REQ  = 1'b0;
    STALL_IF  = 1'b0;
    STALL_ID  = 1'b0;
    STALL_EX  = 1'b0;
    STALL_MEM = 1'b0;
    FLUSH_ID  = 1'b0;
    FLUSH_EX  = 1'b0;
    FLUSH_WB  = 1'b0;
    if (rst) begin
      if (state == FAULT) begin
        STALL_IF  = 1'b1;
        STALL_ID  = 1'b1;
        STALL_EX  = 1'b1;
        STALL_MEM = 1'b1;
        FLUSH_WB  = 1'b1;
      end else begin
        DMEM_REQ = access;
        if (mem_busy) begin
          STALL_IF  = 1'b1;
          STALL_ID  = 1'b1;
          STALL_EX  = 1'b1;
          STALL_MEM = 1'b1;
          FLUSH_WB  = 1'b1;
        end else if (BRANCH_TAKEN_EX) begin
          FLUSH_ID = 1'b1;
          FLUSH_EX = 1'b1;
        end else if (load_use) begin
          STALL_IF = 1'b1;
          STALL_ID = 1'b1;
          FLUSH_EX = 1'b1;
        end
      end
    end
  end

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (STALL_IF) stall_cnt <= stall_cnt + CNT_W'(1);
      if (FLUSH_ID) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign MEM_FAULT   = mem_fault;
  assign STALL_COUNT = stall_cnt;
  assign FLUSH_COUNT = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int TO    = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mr_ex, u1, u2, br, mrm, mwm, rdy;
  logic [4:0] rd_ex, rs1, rs2;
  logic dmem_req, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, mem_fault;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [8:0] act_out, exp_out;

  int checks   = 0;
  int failures = 0;

  // model: consecutive not-ready cycles of the current access, fault flag, counters
  int unsigned mdl_pend, mdl_stall, mdl_flush;
  bit          mdl_faulted;

  always #5 clk = ~clk;

  assign act_out = {dmem_req, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, mem_fault};

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .MEMREAD_EX(mr_ex), .RD_EX(rd_ex), .RS1_ID(rs1), .RS2_ID(rs2),
    .USES_RS1_ID(u1), .USES_RS2_ID(u2), .BRANCH_TAKEN_EX(br),
    .MEMREAD_MEM(mrm), .MEMWRITE_MEM(mwm), .DMEM_READY(rdy),
    .DMEM_REQ(dmem_req), .STALL_IF(s_if), .STALL_ID(s_id), .STALL_EX(s_ex),
    .STALL_MEM(s_mem), .FLUSH_ID(f_id), .FLUSH_EX(f_ex), .FLUSH_WB(f_wb),
    .MEM_FAULT(mem_fault), .STALL_COUNT(stall_count), .FLUSH_COUNT(flush_count)
  );

  // Output bits: {REQ, S_IF, S_ID, S_EX, S_MEM, F_ID, F_EX, F_WB, FAULT}
  function automatic logic [8:0] predict();
    bit access, lu;
    access = mrm | mwm;
    lu = mr_ex && (rd_ex != 5'd0) && ((u1 && rs1 == rd_ex) || (u2 && rs2 == rd_ex));
    if (!rst)        return 9'b0;
    if (mdl_faulted) return 9'b0_1111_0011;
    if (!rdy && (mdl_pend > 0 || access)) return {access, 8'b1111_0010};
    if (br)          return {access, 8'b0000_1100};
    if (lu)          return {access, 8'b1100_0100};
    return {access, 8'b0};
  endfunction

  task automatic model_reset();
    mdl_pend = 0; mdl_stall = 0; mdl_flush = 0; mdl_faulted = 0;
  endtask

  task automatic model_clock();
    mdl_stall += exp_out[7];
    mdl_flush += exp_out[3];
    if (!mdl_faulted) begin
      if (exp_out[7] && exp_out[1]) begin
        mdl_pend++;
        if (mdl_pend > TO) mdl_faulted = 1;
      end else begin
        mdl_pend = 0;
      end
    end
  endtask

  task automatic set_in(input bit a_mr, input logic [4:0] a_rd, a_rs1, a_rs2,
                        input bit a_u1, a_u2, a_br, a_mrm, a_mwm, a_rdy);
    mr_ex = a_mr; rd_ex = a_rd; rs1 = a_rs1; rs2 = a_rs2;
    u1 = a_u1; u2 = a_u2; br = a_br; mrm = a_mrm; mwm = a_mwm; rdy = a_rdy;
  endtask

  task automatic eval();
    @(negedge clk);
    exp_out = predict();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_clock();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    set_in(1, 5, 5, 0, 1, 0, 1, 1, 0, 0);
    #2;
    checks++;
    if (act_out !== 9'b0 || stall_count !== '0 || flush_count !== '0) begin
      failures++;
      $display("FAIL reset_hold out=%b exp=000000000 sc=%0d fc=%0d", act_out, stall_count, flush_count);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    checks++;
    if (act_out !== exp_out || act_out !== 9'b0 || stall_count !== '0) begin
      failures++;
      $display("FAIL reset_release out=%b exp=%b sc=%0d", act_out, exp_out, stall_count);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_in(1, 5, 5, 9, 1, 1, 0, 0, 0, 0);
    eval();
    checks++;
    if (act_out !== exp_out || act_out !== 9'b0_1100_0100) begin
      failures++;
      $display("FAIL load_use_hit out=%b exp=%b", act_out, exp_out);
    end
    tick();
    set_in(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    eval();
    checks++;
    if (act_out !== exp_out || act_out !== 9'b0 || stall_count !== 8'd1) begin
      failures++;
      $display("FAIL load_use_x0 out=%b exp=%b sc=%0d exp_sc=1", act_out, exp_out, stall_count);
    end
    tick();
    set_in(1, 7, 3, 7, 1, 0, 0, 0, 0, 0);
    eval();
    checks++;
    if (act_out !== exp_out || act_out !== 9'b0) begin
      failures++;
      $display("FAIL load_use_unused_rs2 out=%b exp=%b", act_out, exp_out);
    end
    tick();
  endtask

  task automatic test_branch();
    set_in(1, 7, 7, 7, 1, 1, 1, 0, 0, 0);
    eval();
    checks++;
    if (act_out !== exp_out || act_out !== 9'b0_0000_1100) begin
      failures++;
      $display("FAIL branch_over_load_use out=%b exp=%b", act_out, exp_out);
    end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    checks++;
    if (flush_count !== 8'd1 || stall_count !== 8'd1 || act_out !== exp_out) begin
      failures++;
      $display("FAIL branch_counts fc=%0d exp_fc=1 sc=%0d exp_sc=1 out=%b", flush_count, stall_count, act_out);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    int n_stall = 0, n_req = 0;
    logic [8:0] want;
    for (int c = 0; c < 5; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, c < 4, 0, c == 3);
      eval();
      want = (c < 3) ? 9'b1_1111_0010 : (c == 3) ? 9'b1_0000_0000 : 9'b0;
      checks++;
      if (act_out !== exp_out || act_out !== want ||
          stall_count !== mdl_stall[CNT_W-1:0]) begin
        failures++;
        $display("FAIL mem_wait c=%0d out=%b exp=%b sc=%0d exp_sc=%0d", c, act_out, want, stall_count, mdl_stall[CNT_W-1:0]);
      end
      n_stall += int'(s_if);
      n_req   += int'(dmem_req);
      tick();
    end
    checks++;
    if (n_stall != 3 || n_req != 4) begin
      failures++;
      $display("FAIL mem_wait_len stalls=%0d exp=3 req=%0d exp=4", n_stall, n_req);
    end
  endtask

  task automatic test_branch_during_wait();
    logic [8:0] want;
    for (int c = 0; c < 4; c++) begin
      set_in(0, 0, 0, 0, 0, 0, c < 3, 0, c < 3, c == 2);
      eval();
      want = (c < 2) ? 9'b1_1111_0010 : (c == 2) ? 9'b1_0000_1100 : 9'b0;
      checks++;
      if (act_out !== exp_out || act_out !== want ||
          flush_count !== mdl_flush[CNT_W-1:0]) begin
        failures++;
        $display("FAIL branch_in_wait c=%0d out=%b exp=%b fc=%0d exp_fc=%0d", c, act_out, want, flush_count, mdl_flush[CNT_W-1:0]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [8:0] want;
    for (int c = 0; c < 8; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, c >= 6);
      eval();
      want = (c < 5) ? 9'b1_1111_0010 : 9'b0_1111_0011;
      checks++;
      if (act_out !== exp_out || act_out !== want) begin
        failures++;
        $display("FAIL timeout c=%0d out=%b exp=%b", c, act_out, want);
      end
      tick();
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_out !== 9'b0 || stall_count !== '0 || flush_count !== '0) begin
      failures++;
      $display("FAIL timeout_rst out=%b exp=000000000 sc=%0d fc=%0d", act_out, stall_count, flush_count);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    checks++;
    if (act_out !== exp_out || act_out !== 9'b0) begin
      failures++;
      $display("FAIL timeout_cleared out=%b exp=%b", act_out, exp_out);
    end
    tick();
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 2; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      eval();
      checks++;
      if (act_out !== exp_out) begin
        failures++;
        $display("FAIL async_pre c=%0d out=%b exp=%b", c, act_out, exp_out);
      end
      tick();
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_out !== 9'b0 || stall_count !== '0) begin
      failures++;
      $display("FAIL async_rst out=%b exp=000000000 sc=%0d", act_out, stall_count);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, c < 2, c == 1);
      eval();
      checks++;
      if (act_out !== exp_out || stall_count !== mdl_stall[CNT_W-1:0]) begin
        failures++;
        $display("FAIL async_post c=%0d out=%b exp=%b sc=%0d exp_sc=%0d", c, act_out, exp_out, stall_count, mdl_stall[CNT_W-1:0]);
      end
      tick();
    end
  endtask

  task automatic test_counter_wrap();
    for (int c = 0; c < 300; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      eval();
      checks++;
      if (act_out !== exp_out || stall_count !== mdl_stall[CNT_W-1:0]) begin
        failures++;
        $display("FAIL counter_wrap c=%0d out=%b exp=%b sc=%0d exp_sc=%0d", c, act_out, exp_out, stall_count, mdl_stall[CNT_W-1:0]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit hold_r, hold_w;
    #2 rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (mdl_faulted && ($urandom_range(0, 3) == 0)) begin
        rst = 1'b0;
        model_reset();
        #2 rst = 1'b1;
      end
      hold_r = mrm; hold_w = mwm;
      set_in($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 1));
      if (mdl_pend > 0) begin
        mrm = hold_r; mwm = hold_w;
      end
      eval();
      checks++;
      if (act_out !== exp_out || stall_count !== mdl_stall[CNT_W-1:0] ||
          flush_count !== mdl_flush[CNT_W-1:0]) begin
        failures++;
        $display("FAIL random c=%0d out=%b exp=%b sc=%0d/%0d fc=%0d/%0d", c, act_out, exp_out,
                 stall_count, mdl_stall[CNT_W-1:0], flush_count, mdl_flush[CNT_W-1:0]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_during_wait();
    test_timeout();
    test_async_reset();
    test_counter_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipelined RISC-V core. It detects load-use hazards, taken-branch redirects and multi-cycle data-memory accesses. It drives per-stage hold/bubble controls to the IF/ID, ID/EX, EX/MEM and MEM/WB registers and owns the data-memory request handshake. A timeout watchdog and two performance counters are included.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum MEM_WAIT cycles before fault (≥1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- MEMREAD_EX  in  1  instruction in EX is a load.
- RD_EX  in  5  destination register of the EX instruction.
- RS1_ID, RS2_ID  in  5 each  source registers of the ID instruction.
- USES_RS1_ID, USES_RS2_ID  in  1 each  ID instruction actually reads rs1/rs2.
- BRANCH_TAKEN_EX  in  1  branch/jump in EX resolved taken.
- MEMREAD_MEM, MEMWRITE_MEM  in  1 each  MEM-stage access type.
- DMEM_READY  in  1  data memory completes the access this cycle.
- DMEM_REQ  out  1  data-memory request.
- STALL_IF, STALL_ID, STALL_EX, STALL_MEM  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register.
- FLUSH_ID, FLUSH_EX, FLUSH_WB  out  1 each  load a bubble into IF-ID / ID-EX / MEM-WB.
- MEM_FAULT  out  1  sticky memory-timeout fault.
- STALL_COUNT, FLUSH_COUNT  out  CNT_W each  performance counters.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Outputs are Mealy, derived from the registered state and current inputs.
- ACCESS = MEMREAD_MEM | MEMWRITE_MEM. LOAD_USE = MEMREAD_EX & RD_EX≠0 & ((USES_RS1_ID & RS1_ID==RD_EX) | (USES_RS2_ID & RS2_ID==RD_EX)).
- DMEM_REQ = ACCESS in RUN and MEM_WAIT. It is 0 in FAULT.
- Priority in RUN, and on the MEM_WAIT exit cycle: memory wait > taken branch > load-use.
  - ACCESS & !DMEM_READY: assert all four STALL_* and FLUSH_WB. Go to MEM_WAIT and clear the wait counter.
  - Otherwise, if BRANCH_TAKEN_EX: assert FLUSH_ID and FLUSH_EX, with no stall. A load-use in the same cycle is ignored.
  - Otherwise, if LOAD_USE: assert STALL_IF, STALL_ID and FLUSH_EX for exactly one cycle. The state stays RUN.
- MEM_WAIT:
  - While DMEM_READY=0: all STALL_* and FLUSH_WB are asserted, DMEM_REQ stays high, and the wait counter increments.
  - When DMEM_READY=1: stalls and FLUSH_WB drop, MEM/WB captures the result, branch and load-use checks apply in that same cycle, and the next state is RUN.
  - If the wait counter reaches TIMEOUT_CYCLES-1 with DMEM_READY still 0: go to FAULT.
- FAULT: all STALL_* asserted, FLUSH_WB asserted, DMEM_REQ=0, MEM_FAULT=1. The FSM stays in FAULT until reset.
- Single-cycle memory (DMEM_READY=1 in the request cycle) never leaves RUN.
- STALL_COUNT increments in every cycle with STALL_IF=1. FLUSH_COUNT increments in every cycle with FLUSH_ID=1. Both wrap modulo 2^CNT_W.

## Timing
- Reset (rst low, asynchronous): state=RUN, wait counter=0, MEM_FAULT=0, both counters=0. All outputs are forced to 0 while rst is low.
- Hazard outputs are combinational, meaning zero-latency in the cycle the condition is present. Only the state, the counters and MEM_FAULT are registered.
- Load-use costs 1 bubble. A taken branch costs 2 bubbles.
- A memory wait of N cycles (READY arrives N cycles after REQ rises) costs N stall cycles.
- Handshake: once DMEM_REQ rises, it stays high with the MEM-stage address/data frozen until the cycle DMEM_READY=1.
- Reset deasserted mid-wait returns to RUN. Any pending access is re-issued only if ACCESS is still presented.

## Structure
- pipe_ctrl_pkg contains: typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} pipe_ctrl_state_t, and constant REG_X0 = 5'd0.
- One sub-module, load_use_detect: the combinational LOAD_USE comparator, also reused by the forwarding unit.
- Wait counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Load x5 in EX, ID reads rs1=x5 → one cycle of STALL_IF=STALL_ID=FLUSH_EX=1, STALL_COUNT=1. Repeat with RD_EX=x0 → no stall.
- BRANCH_TAKEN_EX=1 together with LOAD_USE → FLUSH_ID=FLUSH_EX=1, STALLs=0, FLUSH_COUNT=1.
- Load in MEM, DMEM_READY low 3 cycles then high → state MEM_WAIT for 3 cycles, all stalls plus FLUSH_WB for 3 cycles, DMEM_REQ held 4 cycles, RUN on the 4th cycle.
- TIMEOUT_CYCLES=4, READY never rises → FAULT after 4 wait cycles, MEM_FAULT=1, DMEM_REQ=0. rst pulse → all cleared.
- Taken branch in EX while the MEM wait is pending → no flush during the wait, FLUSH_ID/FLUSH_EX asserted on the READY cycle.
- rst asserted asynchronously in MEM_WAIT mid-cycle → outputs 0 immediately, state RUN after release.
